// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8 data bits LSB first, optional parity, one stop bit
// (two stop bits when UART_TX_TWO_STOP_EN is defined). Bit timing comes from the
// rising edges of the baud generator's sample_clk level; every bit spans OVS ticks.
//
// Parameters:
//   OVS       sample_clk ticks per bit (2..16)
//   IDLE_LVL  txd level when idle, in reset or disabled
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   sample_clk   baud-generator level; each rising edge is one tick
//   tx_en        enable; low aborts any frame and forces idle
//   no_parity    1 = frame carries no parity bit
//   ev_parity    1 = even parity, 0 = odd parity
//   tx_load      one-clk strobe, accepted only while tx_ready=1
//   tx_data      byte to send
//   tx_ready     idle and enabled, a load is accepted (registered)
//   txd          serial output (registered)
//   tx_ok        one-clk pulse at the end of the stop bit(s) (registered)
// Macro: UART_TX_TWO_STOP_EN selects two stop bits.

module uart_tx #(
  parameter int unsigned OVS      = 16,
  parameter logic        IDLE_LVL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_clk,
  input  logic       tx_en,
  input  logic       no_parity,
  input  logic       ev_parity,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_ok
);

  localparam int unsigned TICK_W = 4;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic                sc_prev_q, sc_prev_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                np_q, np_d;
  logic                txd_q, txd_d;
  logic                tx_ok_q, tx_ok_d;
  logic                tx_ready_q, tx_ready_d;
`ifdef UART_TX_TWO_STOP_EN
  logic                stop_cnt_q, stop_cnt_d;
`endif

  logic tick;
  logic last_tick;
  logic load;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sc_prev_q  <= 1'b0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      np_q       <= 1'b0;
      txd_q      <= IDLE_LVL;
      tx_ok_q    <= 1'b0;
      tx_ready_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sc_prev_q  <= sc_prev_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      np_q       <= np_d;
      txd_q      <= txd_d;
      tx_ok_q    <= tx_ok_d;
      tx_ready_q <= tx_ready_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    sc_prev_d  = sample_clk;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    np_d       = np_q;
    txd_d      = txd_q;
    tx_ok_d    = 1'b0;
    tx_ready_d = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif

    tick      = sample_clk & ~sc_prev_q & tx_en;
    last_tick = tick & (tick_cnt_q == TICK_LAST);
    // tx_ready_q already implies idle; tx_en is rechecked so an abort beats a load
    load      = tx_load & tx_ready_q & tx_en;

    // Shared per-bit tick counter; wrapping marks the end of the current bit
    if ((state_q != S_IDLE) && tick) begin
      tick_cnt_d = last_tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        txd_d = IDLE_LVL;
        if (load) begin
          state_d    = S_START;
          shift_d    = tx_data;
          par_d      = ev_parity ? ^tx_data : ~^tx_data;
          np_d       = no_parity;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          txd_d      = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
          stop_cnt_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (last_tick) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (last_tick) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (np_q) begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end else begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            txd_d     = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (last_tick) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (last_tick) begin
`ifdef UART_TX_TWO_STOP_EN
          if (!stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = S_IDLE;
            txd_d      = IDLE_LVL;
            tx_ok_d    = 1'b1;
          end
`else
          state_d = S_IDLE;
          txd_d   = IDLE_LVL;
          tx_ok_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = IDLE_LVL;
      end
    endcase

    // Disable aborts the frame unconditionally; the byte in flight is dropped
    if (!tx_en) begin
      state_d    = S_IDLE;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      txd_d      = IDLE_LVL;
      tx_ok_d    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_d = 1'b0;
`endif
    end

    // Ready only after a full idle cycle, so it rises the cycle after tx_ok
    tx_ready_d = tx_en & (state_q == S_IDLE) & (state_d == S_IDLE);
  end

  assign tx_ready = tx_ready_q;
  assign txd      = txd_q;
  assign tx_ok    = tx_ok_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: frame-level reference model (frame as a bit array indexed
// by ticks since load) compared every cycle, plus directed frames with literal bit
// patterns and tick counts, then randomized traffic.
module tb_uart_tx;

  localparam int OVS = 16;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_clk = 1'b0;
  logic       tx_en;
  logic       no_parity;
  logic       ev_parity;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       txd;
  logic       tx_ok;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.OVS(OVS), .IDLE_LVL(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .tx_en      (tx_en),
    .no_parity  (no_parity),
    .ev_parity  (ev_parity),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .tx_ok      (tx_ok)
  );

  always #5 clk = ~clk;

  // Baud level: fixed 4-clk period, or random half periods of 1..3 clks
  bit sc_fixed = 1'b1;
  int sc_cnt   = 0;
  always @(negedge clk) begin
    if (sc_cnt == 0) begin
      sample_clk = ~sample_clk;
      sc_cnt     = sc_fixed ? 1 : int'($urandom_range(2, 0));
    end else begin
      sc_cnt = sc_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bit levels; txd = bits[ticks/OVS]
  logic m_bits [0:11];
  int   m_nbits  = 0;
  int   m_ticks  = 0;
  bit   m_active = 1'b0;
  bit   m_ready  = 1'b0;
  bit   m_txd    = 1'b1;
  bit   m_ok     = 1'b0;
  bit   sc_prev  = 1'b0;
  bit   m_tick;
  int   tick_total = 0;
  int   ok_total   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_ready  = 1'b0;
      m_txd    = 1'b1;
      m_ok     = 1'b0;
      m_ticks  = 0;
      sc_prev  = 1'b0;
    end else begin
      m_tick  = sample_clk && !sc_prev && tx_en;
      sc_prev = sample_clk;
      if (m_tick) tick_total++;
      m_ok = 1'b0;
      if (!tx_en) begin
        m_active = 1'b0;
        m_ready  = 1'b0;
        m_txd    = 1'b1;
      end else if (m_active) begin
        m_ready = 1'b0;
        if (m_tick) m_ticks++;
        if (m_ticks == m_nbits * OVS) begin
          m_active = 1'b0;
          m_ok     = 1'b1;
          m_txd    = 1'b1;
        end else begin
          m_txd = m_bits[m_ticks / OVS];
        end
      end else if (tx_load && m_ready) begin
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[1 + i] = tx_data[i];
        m_nbits = 9;
        if (!no_parity) begin
          // even parity: bit makes the total count of ones even
          m_bits[9] = ev_parity ? ($countones(tx_data) % 2 == 1) : ($countones(tx_data) % 2 == 0);
          m_nbits   = 10;
        end
        for (int i = m_nbits; i < 12; i++) m_bits[i] = 1'b1;
        m_nbits  = m_nbits + NSTOP;
        m_active = 1'b1;
        m_ticks  = 0;
        m_txd    = 1'b0;
        m_ready  = 1'b0;
      end else begin
        m_ready = 1'b1;
        m_txd   = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (tx_ok === 1'b1) ok_total++;
    chk("cyc_txd", txd, m_txd);
    chk("cyc_tx_ready", tx_ready, m_ready);
    chk("cyc_tx_ok", tx_ok, m_ok);
  end

  function automatic logic [11:0] with_stop(input logic [11:0] lit, input int nb1);
    return (NSTOP == 2) ? (lit | (12'd1 << nb1)) : lit;
  endfunction

  // Sends one frame with a fixed baud; records txd mid-bit for each bit.
  // Optional: inject a load, abort (tx_en=0) or reset at a given tick count.
  task automatic run_frame(input logic [7:0] d, input logic np, input logic ev,
                           input int inj_tick, input int abort_tick, input int rst_tick,
                           output logic [11:0] bits, output int ticks,
                           output int wait_cyc, output int t_start);
    int n;
    bit inj_done;
    bit inj_pend;
    bits     = '0;
    ticks    = -1;
    wait_cyc = 0;
    inj_done = 1'b0;
    inj_pend = 1'b0;
    while (tx_ready !== 1'b1 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    t_start = tick_total;
    if (tx_ready !== 1'b1) begin
      chk("ready_wait", tx_ready, 1);
      return;
    end
    tx_data   = d;
    no_parity = np;
    ev_parity = ev;
    tx_load   = 1'b1;
    @(negedge clk);
    tx_load   = 1'b0;
    // config flips after the load must not disturb the frame
    no_parity = ~np;
    ev_parity = ~ev;
    t_start   = tick_total;
    for (int c = 0; c < 4000; c++) begin
      n = tick_total - t_start;
      if (inj_pend) begin
        tx_load  = 1'b0;
        inj_pend = 1'b0;
      end
      if ((n % OVS) == OVS / 2 && (n / OVS) < 12) bits[n / OVS] = txd;
      if (n == inj_tick && !inj_done) begin
        chk("busy_ready", tx_ready, 0);
        tx_data  = 8'h99;
        tx_load  = 1'b1;
        inj_done = 1'b1;
        inj_pend = 1'b1;
      end
      if (n == abort_tick) begin
        tx_en = 1'b0;
        @(negedge clk);
        chk("abort_txd", txd, 1);
        chk("abort_ready", tx_ready, 0);
        chk("abort_ok", tx_ok, 0);
        return;
      end
      if (n == rst_tick) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_txd", txd, 1);
        chk("rst_mid_ready", tx_ready, 0);
        chk("rst_mid_ok", tx_ok, 0);
        rst = 1'b0;
        return;
      end
      if (tx_ok === 1'b1) begin
        ticks = n;
        chk("ready_at_ok", tx_ready, 0);
        return;
      end
      @(negedge clk);
    end
    chk("frame_timeout", 0, 1);
  endtask

  logic [11:0] bits;
  int ticks, wc, ts, ok0, tk_ok;

  initial begin
    rst       = 1'b1;
    tx_en     = 1'b1;
    tx_load   = 1'b0;
    tx_data   = 8'h00;
    no_parity = 1'b1;
    ev_parity = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 0);
    chk("rst_ok", tx_ok, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", tx_ready, 1);

    // 0x55, no parity
    ok0 = ok_total;
    run_frame(8'h55, 1'b1, 1'b1, -1, -1, -1, bits, ticks, wc, ts);
    chk("t1_bits", bits, with_stop(12'h2AA, 10));
    chk("t1_ticks", ticks, OVS * (9 + NSTOP));
    @(negedge clk);
    chk("t1_ok_count", ok_total - ok0, 1);
    chk("t1_ready_after_ok", tx_ready, 1);

    // 0xA5 even parity then odd parity
    run_frame(8'hA5, 1'b0, 1'b1, -1, -1, -1, bits, ticks, wc, ts);
    chk("t2_even_bits", bits, with_stop(12'h54A, 11));
    chk("t2_even_ticks", ticks, OVS * (10 + NSTOP));
    @(negedge clk);
    run_frame(8'hA5, 1'b0, 1'b0, -1, -1, -1, bits, ticks, wc, ts);
    chk("t2_odd_bits", bits, with_stop(12'h74A, 11));
    chk("t2_odd_ticks", ticks, OVS * (10 + NSTOP));
    @(negedge clk);

    // back-to-back 0x00 then 0xFF
    ok0 = ok_total;
    run_frame(8'h00, 1'b1, 1'b0, -1, -1, -1, bits, ticks, wc, ts);
    chk("t3a_bits", bits, with_stop(12'h200, 10));
    tk_ok = tick_total;
    run_frame(8'hFF, 1'b1, 1'b0, -1, -1, -1, bits, ticks, wc, ts);
    chk("t3_ready_wait", wc, 1);
    chk("t3_tick_gap", ts - tk_ok, 0);
    chk("t3b_bits", bits, with_stop(12'h3FE, 10));
    chk("t3b_ticks", ticks, OVS * (9 + NSTOP));
    @(negedge clk);
    chk("t3_ok_count", ok_total - ok0, 2);

    // load during DATA is ignored
    run_frame(8'h3C, 1'b1, 1'b0, 40, -1, -1, bits, ticks, wc, ts);
    chk("t4_bits", bits, with_stop(12'h278, 10));
    chk("t4_ticks", ticks, OVS * (9 + NSTOP));
    @(negedge clk);

    // abort at tick 5 of data bit 3, then a clean frame
    ok0 = ok_total;
    run_frame(8'hC3, 1'b1, 1'b0, -1, 4 * OVS + 5, -1, bits, ticks, wc, ts);
    repeat (60) @(negedge clk);
    chk("t5_no_ok", ok_total - ok0, 0);
    chk("t5_idle_txd", txd, 1);
    chk("t5_idle_ready", tx_ready, 0);
    tx_en = 1'b1;
    @(negedge clk);
    run_frame(8'h81, 1'b1, 1'b0, -1, -1, -1, bits, ticks, wc, ts);
    chk("t5_bits", bits, with_stop(12'h302, 10));
    chk("t5_ticks", ticks, OVS * (9 + NSTOP));
    @(negedge clk);

    // reset during PARITY
    ok0 = ok_total;
    run_frame(8'hA5, 1'b0, 1'b1, -1, -1, 9 * OVS + 3, bits, ticks, wc, ts);
    @(negedge clk);
    chk("t6_ready_after_rst", tx_ready, 1);
    chk("t6_no_ok", ok_total - ok0, 0);

    // randomized traffic
    sc_fixed = 1'b0;
    ok0 = ok_total;
    for (int c = 0; c < 14000; c++) begin
      @(negedge clk);
      tx_load = ($urandom_range(5, 0) == 0);
      tx_data = 8'($urandom);
      if ($urandom_range(40, 0) == 0) begin
        no_parity = 1'($urandom);
        ev_parity = 1'($urandom);
      end
      if (tx_en && $urandom_range(2500, 0) == 0) tx_en = 1'b0;
      else if (!tx_en && $urandom_range(15, 0) == 0) tx_en = 1'b1;
      rst = ($urandom_range(6000, 0) == 0);
    end
    rst     = 1'b0;
    tx_en   = 1'b1;
    tx_load = 1'b0;
    repeat (4) @(negedge clk);
    chk("rand_frames_seen", (ok_total - ok0 >= 3), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
